// File: rtl/puf_pkg.sv
// Shared types and helpers for the PUF challenge controller.
// Holds the FSM state encoding, challenge width and the challenge LFSR step.
package puf_pkg;

  localparam int CHALL_W = 8;
  localparam logic [CHALL_W-1:0] LFSR_TAPS = 8'hB8;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETUP,
    S_RUN,
    S_CAPTURE,
    S_DONE
  } state_t;

  // Galois right-shift step; a nonzero value never maps to zero.
  function automatic logic [CHALL_W-1:0] lfsr_next(input logic [CHALL_W-1:0] c);
    return (c >> 1) ^ (c[0] ? LFSR_TAPS : '0);
  endfunction

endpackage

// File: rtl/chall_lfsr.sv
// Challenge register: loads a seed (zero replaced by 1 so the LFSR cannot lock up)
// and advances one Galois LFSR step on request.
module chall_lfsr
  import puf_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               i_load,
  input  logic               i_step,
  input  logic [CHALL_W-1:0] i_seed,
  output logic [CHALL_W-1:0] o_chall
);

  logic [CHALL_W-1:0] r_chall;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_chall <= '0;
    end else if (i_load) begin
      r_chall <= (i_seed == '0) ? CHALL_W'(1) : i_seed;
    end else if (i_step) begin
      r_chall <= lfsr_next(r_chall);
    end
  end

  assign o_chall = r_chall;

endmodule

// File: rtl/puf_ctrl.sv
// Challenge sequencer and response collector for one PUF bit cell.
// Optional macro PUF_VOTE_EN: evaluate each challenge 3 times and store the majority.
module puf_ctrl
  import puf_pkg::*;
#(
  parameter int N_BITS  = 16,
  parameter int TIMEOUT = 1024
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [CHALL_W-1:0] seed,
  output logic               busy,
  output logic               done,
  output logic               err,
  output logic [N_BITS-1:0]  resp_word,
  output logic [CHALL_W-1:0] puf_chall,
  output logic               puf_en,
  output logic               puf_rst,
  input  logic               puf_resp,
  input  logic               puf_finish
);

  localparam int KW = (N_BITS > 1) ? $clog2(N_BITS) : 1;
  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [KW-1:0] K_LAST = KW'(N_BITS - 1);
  localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT - 1);

  state_t r_state;
  state_t w_next;

  logic [KW-1:0]     r_k;
  logic [TW-1:0]     r_tcnt;
  logic [N_BITS-1:0] r_shadow;
  logic [N_BITS-1:0] r_resp_word;
  logic              r_err;

  logic              w_tlimit;
  logic              w_eval_end;
  logic              w_timeout;
  logic              w_sample;
  logic              w_last_eval;
  logic              w_bit_cap;
  logic              w_load;
  logic              w_step;
  logic [N_BITS-1:0] w_shadow_next;

  // Finish has priority over a simultaneous timeout.
  assign w_tlimit   = (r_tcnt == T_LAST);
  assign w_eval_end = (r_state == S_RUN) && (puf_finish || w_tlimit);
  assign w_timeout  = (r_state == S_RUN) && w_tlimit && !puf_finish;
  assign w_sample   = puf_finish & puf_resp;
  assign w_load     = (r_state == S_IDLE) && start;
  assign w_step     = (r_state == S_CAPTURE) && (r_k != K_LAST);

`ifdef PUF_VOTE_EN
  logic [1:0] r_eval;
  logic [1:0] r_vote;

  assign w_last_eval = (r_eval == 2'd2);
  assign w_bit_cap   = r_vote[1];

  always_ff @(posedge clk) begin
    if (rst || w_load || (r_state == S_CAPTURE)) begin
      r_eval <= '0;
      r_vote <= '0;
    end else if (w_eval_end) begin
      r_eval <= r_eval + 2'd1;
      r_vote <= r_vote + {1'b0, w_sample};
    end
  end
`else
  logic r_bit;

  assign w_last_eval = 1'b1;
  assign w_bit_cap   = r_bit;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_bit <= 1'b0;
    end else if (w_eval_end) begin
      r_bit <= w_sample;
    end
  end
`endif

  always_comb begin
    w_shadow_next = r_shadow;
    for (int i = 0; i < N_BITS; i++) begin
      if (r_k == KW'(i)) w_shadow_next[i] = w_bit_cap;
    end
  end

  chall_lfsr u_lfsr (
    .clk     (clk),
    .rst     (rst),
    .i_load  (w_load),
    .i_step  (w_step),
    .i_seed  (seed),
    .o_chall (puf_chall)
  );

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next  = r_state;
    busy    = (r_state != S_IDLE);
    done    = 1'b0;
    puf_en  = 1'b0;
    puf_rst = 1'b0;
    case (r_state)
      S_IDLE:    if (start) w_next = S_SETUP;
      S_SETUP: begin
        puf_rst = 1'b1;
        w_next  = S_RUN;
      end
      S_RUN: begin
        puf_en = 1'b1;
        if (w_eval_end) w_next = w_last_eval ? S_CAPTURE : S_SETUP;
      end
      S_CAPTURE: w_next = (r_k == K_LAST) ? S_DONE : S_SETUP;
      S_DONE: begin
        done   = 1'b1;
        w_next = S_IDLE;
      end
      default:   w_next = S_IDLE;
    endcase
  end

  // The finished word is published on leaving CAPTURE so it is valid alongside done.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_k         <= '0;
      r_tcnt      <= '0;
      r_shadow    <= '0;
      r_resp_word <= '0;
      r_err       <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_k      <= '0;
            r_shadow <= '0;
            r_err    <= 1'b0;
          end
        end
        S_SETUP: r_tcnt <= '0;
        S_RUN: begin
          if (!w_tlimit) r_tcnt <= r_tcnt + 1'b1;
          if (w_timeout) r_err <= 1'b1;
        end
        S_CAPTURE: begin
          r_shadow <= w_shadow_next;
          if (r_k == K_LAST) r_resp_word <= w_shadow_next;
          else               r_k <= r_k + 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign err       = r_err;
  assign resp_word = r_resp_word;

endmodule

// File: tb/tb_puf_ctrl.sv
// Scoreboard bench for puf_ctrl with a behavioural PUF cell model.
// Honours PUF_VOTE_EN: the reference model then takes a 3-way majority per challenge.
module tb_puf_ctrl;

  localparam int NB   = 4;
  localparam int TO   = 16;
  localparam int HANG = 1000;
`ifdef PUF_VOTE_EN
  localparam int EV = 3;
`else
  localparam int EV = 1;
`endif

  typedef struct {
    int lat;
    bit resp;
  } eval_t;

  typedef struct {
    logic [NB-1:0] word;
    logic          err;
  } res_t;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic [7:0]    seed = 8'h00;
  logic          busy, done, err, puf_en, puf_rst;
  logic [NB-1:0] resp_word;
  logic [7:0]    puf_chall;
  logic          puf_resp = 1'b0;
  logic          puf_finish = 1'b0;

  int checks = 0;
  int failures = 0;

  eval_t      planQ[$];
  eval_t      stimPlan[NB*EV];
  logic [7:0] challQ[$];
  int         dwellQ[$];
  res_t       resQ[$];
  bit         skipDwell = 0;

  puf_ctrl #(.N_BITS(NB), .TIMEOUT(TO)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .seed       (seed),
    .busy       (busy),
    .done       (done),
    .err        (err),
    .resp_word  (resp_word),
    .puf_chall  (puf_chall),
    .puf_en     (puf_en),
    .puf_rst    (puf_rst),
    .puf_resp   (puf_resp),
    .puf_finish (puf_finish)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      failures++;
      $display("[TB] FAIL %s actual=%0h expected=%0h", name, act, expv);
    end
  endtask

  // Cell model: each puf_rst pulse starts the next planned evaluation; finish fires lat cycles into RUN.
  eval_t cur = '{HANG, 1'b0};
  int    runCnt = 0;
  always @(negedge clk) begin
    if (puf_rst) begin
      cur    = (planQ.size() > 0) ? planQ.pop_front() : '{HANG, 1'b0};
      runCnt = 0;
    end
    if (puf_en) runCnt++;
    puf_finish = puf_en && (runCnt == cur.lat);
    puf_resp   = cur.resp;
  end

  logic [7:0] setChall = 8'h00;
  always @(negedge clk) begin
    if (puf_rst) begin
      setChall = puf_chall;
      if (challQ.size() == 0) checkOutput("unexpected_setup", 1, 0);
      else                    checkOutput("puf_chall", puf_chall, challQ.pop_front());
    end else if (puf_en) begin
      checkOutput("chall_stable_in_run", puf_chall, setChall);
    end
  end

  int dwellCnt = 0;
  always @(negedge clk) begin
    if (puf_en) begin
      dwellCnt++;
    end else if (dwellCnt > 0) begin
      if (skipDwell)              skipDwell = 0;
      else if (dwellQ.size() == 0) checkOutput("unexpected_run", dwellCnt, 0);
      else                        checkOutput("run_dwell", dwellCnt, dwellQ.pop_front());
      dwellCnt = 0;
    end
  end

  always @(negedge clk) begin
    if (done) begin
      if (resQ.size() == 0) begin
        checkOutput("unexpected_done", 1, 0);
      end else begin
        res_t e;
        e = resQ.pop_front();
        checkOutput("resp_word", resp_word, e.word);
        checkOutput("err", err, e.err);
        checkOutput("busy_in_done", busy, 1);
      end
    end
  end

  task automatic fillPlan(input int lat, input bit resp);
    for (int i = 0; i < NB*EV; i++) stimPlan[i] = '{lat, resp};
  endtask

  // Builds expectations from the cell plan, then issues one run and waits for done.
  task automatic applyStimulus(input logic [7:0] s, input bit abuseStart, input bit abuseDone);
    logic [7:0]    c;
    logic [NB-1:0] word;
    logic          e;
    int            votes;
    bit            finished;
    c    = (s == 8'h00) ? 8'h01 : s;
    word = '0;
    e    = 1'b0;
    for (int k = 0; k < NB; k++) begin
      votes = 0;
      for (int v = 0; v < EV; v++) begin
        eval_t p;
        p = stimPlan[k*EV + v];
        planQ.push_back(p);
        challQ.push_back(c);
        dwellQ.push_back((p.lat < TO) ? p.lat : TO);
        if (p.lat <= TO) votes += int'(p.resp);
        else             e = 1'b1;
      end
      word[k] = (EV == 3) ? (votes >= 2) : (votes == 1);
      c = (c >> 1) ^ (c[0] ? 8'hB8 : 8'h00);
    end
    resQ.push_back('{word, e});

    @(negedge clk);
    seed  = s;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    finished = 0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      @(negedge clk);
      start = 1'b0;
      if (abuseStart && cyc == 8) begin
        checkOutput("busy_when_start_abused", busy, 1);
        start = 1'b1;
      end
      if (done) begin
        finished = 1;
        if (abuseDone) start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        checkOutput("done_single_pulse", done, 0);
        checkOutput("busy_after_done", busy, 0);
        break;
      end
    end
    if (!finished) begin
      checkOutput("run_completes_in_budget", 0, 1);
      planQ.delete();
      challQ.delete();
      dwellQ.delete();
      resQ.delete();
    end
    repeat (3) @(negedge clk);
    checkOutput("setups_consumed", challQ.size(), 0);
    checkOutput("results_consumed", resQ.size(), 0);
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL global_watchdog actual=expired required=finish");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checkOutput("reset_busy", busy, 0);
    checkOutput("reset_done", done, 0);
    checkOutput("reset_err", err, 0);
    checkOutput("reset_resp_word", resp_word, 0);
    checkOutput("reset_puf_chall", puf_chall, 0);
    checkOutput("reset_puf_en", puf_en, 0);
    checkOutput("reset_puf_rst", puf_rst, 0);

    $display("[TB] challenge sequence from seed 01");
    fillPlan(5, 1'b1);
    applyStimulus(8'h01, 0, 0);

    $display("[TB] zero seed");
    for (int i = 0; i < NB*EV; i++) stimPlan[i] = '{2 + i, 1'((i / EV) & 1)};
    applyStimulus(8'h00, 0, 0);

    $display("[TB] timeout on challenge 2");
    fillPlan(5, 1'b1);
    for (int v = 0; v < EV; v++) stimPlan[2*EV + v] = '{HANG, 1'b1};
    applyStimulus(8'h5A, 0, 0);

    $display("[TB] finish and timeout collide");
    fillPlan(3, 1'b0);
    for (int v = 0; v < EV; v++) stimPlan[1*EV + v] = '{TO, 1'b1};
    applyStimulus(8'hC3, 0, 0);

    $display("[TB] start pulsed during RUN");
    for (int i = 0; i < NB*EV; i++) stimPlan[i] = '{10, 1'(i & 1)};
    applyStimulus(8'h77, 1, 0);

    $display("[TB] start pulsed during DONE");
    fillPlan(4, 1'b1);
    applyStimulus(8'h2B, 0, 1);

`ifdef PUF_VOTE_EN
    $display("[TB] majority vote 1,0,1");
    fillPlan(3, 1'b0);
    stimPlan[0] = '{3, 1'b1};
    stimPlan[1] = '{4, 1'b0};
    stimPlan[2] = '{5, 1'b1};
    applyStimulus(8'h91, 0, 0);
`endif

    $display("[TB] randomized runs");
    for (int r = 0; r < 12; r++) begin
      for (int i = 0; i < NB*EV; i++) begin
        int sel;
        sel = $urandom_range(0, 9);
        if (sel == 0)      stimPlan[i].lat = HANG;
        else if (sel == 1) stimPlan[i].lat = TO;
        else               stimPlan[i].lat = $urandom_range(1, 12);
        stimPlan[i].resp = 1'($urandom_range(0, 1));
      end
      applyStimulus(8'($urandom_range(0, 255)), 0, 0);
    end

    $display("[TB] reset during RUN");
    fillPlan(5, 1'b1);
    applyStimulus(8'h01, 0, 0);
    planQ.push_back('{HANG, 1'b1});
    challQ.push_back(8'h44);
    @(negedge clk);
    seed  = 8'h44;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    begin
      bit seen;
      seen = 0;
      for (int cyc = 0; cyc < 50; cyc++) begin
        @(negedge clk);
        if (puf_en) begin
          seen = 1;
          break;
        end
      end
      checkOutput("run_entered_before_reset", seen, 1);
    end
    repeat (3) @(negedge clk);
    skipDwell = 1;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checkOutput("midrst_busy", busy, 0);
    checkOutput("midrst_puf_en", puf_en, 0);
    checkOutput("midrst_resp_word", resp_word, 0);
    checkOutput("midrst_err", err, 0);
    checkOutput("midrst_done", done, 0);
    planQ.delete();
    repeat (3) @(negedge clk);

    $display("[TB] run after mid-run reset");
    fillPlan(6, 1'b1);
    stimPlan[0] = '{6, 1'b0};
    applyStimulus(8'h80, 0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
